// File: rtl/axil_rr_master_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite master port between two
// register-access requesters. Each request becomes one single-beat write or
// read. The response is returned to the winner with a one-cycle ack.
//
// Handshake rule: a transfer happens on a rising edge where VALID and READY
// are both high. A VALID, once raised, stays high until that edge. Address
// and data stay stable while VALID is high. Requesters hold req and its
// fields until they sample ack high.
module axil_rr_master_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32   // only 32 is supported
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [1:0]                      req,
  input  logic [1:0]                      req_we,
  input  logic [2*C_M_AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [2*C_M_AXI_DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]                      ack,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [3:0]                      M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            grant_q, grant_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic            gsel;

  // State register and datapath flops; reset abandons any transfer in flight.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;        // requester 0 wins the first contest
      grant_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_resp_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_resp_q   <= rsp_resp_d;
    end
  end

  // Next-state logic: arbitration, AXI phase sequencing, response capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_resp_d   = rsp_resp_q;
    // With both requesting, the one that did not win last time goes next.
    gsel = (req == 2'b11) ? ~last_grant_q : req[1];
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d      = gsel;
          last_grant_d = gsel;
          addr_d       = gsel ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
          wdata_d      = gsel ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
          if (req_we[gsel]) begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d = S_RD_ADDR;
          end
        end
      end
      S_WR: begin
        // AW and W complete independently; leave once both are done.
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY))
          state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          rsp_resp_d = M_AXI_BRESP;
          state_d    = S_DONE;
        end
      end
      S_RD_ADDR: begin
        if (M_AXI_ARREADY) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (M_AXI_RVALID) begin
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == S_WR_RESP);
  assign M_AXI_ARVALID = (state_q == S_RD_ADDR);
  assign M_AXI_RREADY  = (state_q == S_RD_DATA);
  assign busy          = (state_q != S_IDLE);
  assign ack           = (state_q == S_DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;

endmodule

// File: tb/tb_axil_rr_master_arbiter.sv
// Bench for axil_rr_master_arbiter: behavioural AXI4-Lite slave with
// programmable ready delays, a vector table of single transfers, and
// hand-written sequences for arbitration, stalls and reset.
module tb_axil_rr_master_arbiter;

  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [1:0]    req = '0, req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [63:0]   req_wdata = '0;
  logic [1:0]    ack, rsp_resp;
  logic [31:0]   rsp_rdata;
  logic          busy;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic          awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [31:0]   wdata, rdata = '0;
  logic [3:0]    wstrb;
  logic [1:0]    bresp = '0, rresp = '0;

  axil_rr_master_arbiter #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  // ---------------- scoreboard counters ----------------
  int n_pass = 0, n_total = 0;
  int ack_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge ACLK) if (ack != 2'b00) ack_total++;

  // ---------------- behavioural slave ----------------
  // Decides READY/response at the falling edge; handshakes land on the next rising edge.
  int aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
  bit rd_err = 0;
  int aw_tot = 0, w_tot = 0, b_done = 0, ar_tot = 0, r_done = 0;
  logic [AW-1:0] aw_cap, ar_cap;
  logic [31:0]   w_cap;
  logic [31:0]   mem [4];

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_wait = 0; w_wait = 0;
      aw_tot = 0; w_tot = 0; b_done = 0; ar_tot = 0; r_done = 0;
    end else begin
      if (awvalid) begin
        awready = (aw_wait >= aw_delay);
        if (!awready) aw_wait++;
      end else begin
        awready = 0; aw_wait = 0;
      end
      if (awvalid && awready) begin aw_tot++; aw_cap = awaddr; end
      if (wvalid) begin
        wready = (w_wait >= w_delay);
        if (!wready) w_wait++;
      end else begin
        wready = 0; w_wait = 0;
      end
      if (wvalid && wready) begin w_tot++; w_cap = wdata; end
      bvalid = bready && (aw_tot > b_done) && (w_tot > b_done);
      bresp  = 2'b00;
      if (bvalid) begin b_done++; mem[aw_cap[3:2]] = w_cap; end
      arready = arvalid;
      if (arvalid && arready) begin ar_tot++; ar_cap = araddr; end
      rvalid = rready && (ar_tot > r_done);
      rdata  = rd_err ? 32'hDEADBEEF : mem[ar_cap[3:2]];
      rresp  = rd_err ? 2'b10 : 2'b00;
      if (rvalid) r_done++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int who, input bit we, input logic [AW-1:0] a, input logic [31:0] d);
    @(posedge ACLK); #1;
    if (who == 0) begin req_addr[AW-1:0] = a; req_wdata[31:0] = d; end
    else begin req_addr[2*AW-1:AW] = a; req_wdata[63:32] = d; end
    req_we[who] = we;
    req[who] = 1'b1;
  endtask

  // Counts falling edges until ack is seen; cyc = 4 for a zero-wait transfer.
  task automatic wait_ack(output int cyc, output logic [1:0] a, output logic [31:0] rd,
                          output logic [1:0] rs);
    cyc = 0; a = 2'b00; rd = '0; rs = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ACLK); cyc++;
      if (ack != 2'b00) begin a = ack; rd = rsp_rdata; rs = rsp_resp; break; end
    end
    if (a == 2'b00) begin
      n_total++;
      $display("FAIL ack_timeout: got no ack expected ack within 60 cycles");
    end
  endtask

  // Requester drops req on the edge where ack is sampled.
  task automatic release_req(input logic [1:0] mask);
    @(posedge ACLK); #1;
    req = req & ~mask;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          who;
    bit          we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    bit          err;
    logic [1:0]  exp_ack;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t tbl [9];

  int cyc, cyc0;
  logic [1:0] a, rs;
  logic [31:0] rd;
  int b_before, ack_before;
  logic [1:0] exp_seq;

  initial begin
    tbl[0] = '{0, 1, 4'h0, 32'd1, 0, 2'b01, 32'd0, 2'b00};
    tbl[1] = '{0, 1, 4'h4, 32'd2, 0, 2'b01, 32'd0, 2'b00};
    tbl[2] = '{0, 1, 4'h8, 32'd3, 0, 2'b01, 32'd0, 2'b00};
    tbl[3] = '{0, 1, 4'hC, 32'd4, 0, 2'b01, 32'd0, 2'b00};
    tbl[4] = '{1, 0, 4'h0, 32'd0, 0, 2'b10, 32'd1, 2'b00};
    tbl[5] = '{1, 0, 4'h4, 32'd0, 0, 2'b10, 32'd2, 2'b00};
    tbl[6] = '{1, 0, 4'h8, 32'd0, 0, 2'b10, 32'd3, 2'b00};
    tbl[7] = '{1, 0, 4'hC, 32'd0, 0, 2'b10, 32'd4, 2'b00};
    tbl[8] = '{1, 0, 4'h4, 32'd0, 1, 2'b10, 32'hDEADBEEF, 2'b10};
    for (int i = 0; i < 4; i++) mem[i] = '0;

    // Reset state.
    repeat (3) @(negedge ACLK);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    chk("rst_ack_busy", {ack, busy}, 3'b0);
    chk("rst_rsp", {rsp_rdata, rsp_resp}, 34'h0);
    chk("rst_addr_data", {awaddr, wdata}, 36'h0);
    chk("const_prot_strb", {awprot, arprot, wstrb}, 10'h00F);
    @(posedge ACLK); #1 ARESETN = 1'b1;

    // First write by req0, cycle by cycle.
    issue(0, 1, 4'h0, 32'h1);
    @(negedge ACLK);                         // IDLE cycle, grant decided
    chk("w1_idle_valids", {awvalid, wvalid}, 2'b00);
    @(negedge ACLK);                         // WR
    chk("w1_wr_valids", {awvalid, wvalid}, 2'b11);
    chk("w1_wr_fields", {awaddr, wdata, wstrb}, {4'h0, 32'h1, 4'hF});
    @(negedge ACLK);                         // WR_RESP
    chk("w1_bready", {bready, awvalid, wvalid}, 3'b100);
    wait_ack(cyc, a, rd, rs);
    chk("w1_latency", cyc + 3, 4);
    chk("w1_ack", a, 2'b01);
    chk("w1_resp", rs, 2'b00);
    release_req(2'b01);

    // Table of single transfers: four writes then four reads and an error read.
    for (int k = 0; k < 9; k++) begin
      rd_err = tbl[k].err;
      issue(tbl[k].who, tbl[k].we, tbl[k].addr, tbl[k].wdata);
      wait_ack(cyc, a, rd, rs);
      chk($sformatf("v%0d_ack", k), a, tbl[k].exp_ack);
      chk($sformatf("v%0d_rdata", k), rd, tbl[k].exp_rdata);
      chk($sformatf("v%0d_resp", k), rs, tbl[k].exp_resp);
      chk($sformatf("v%0d_latency", k), cyc, 4);
      release_req(tbl[k].who == 0 ? 2'b01 : 2'b10);
      @(negedge ACLK);
      chk($sformatf("v%0d_idle_busy", k), busy, 1'b0);
    end
    rd_err = 0;

    // Both requesting continuously: last winner was 1, so 0,1,0,1.
    @(posedge ACLK); #1;
    req_we = 2'b00; req_addr = {4'h4, 4'h0};
    req = 2'b11;
    exp_seq = 2'b01;
    for (int k = 0; k < 4; k++) begin
      wait_ack(cyc, a, rd, rs);
      chk($sformatf("rr%0d_ack", k), a, exp_seq);
      chk($sformatf("rr%0d_rdata", k), rd, exp_seq == 2'b01 ? 32'd1 : 32'd2);
      chk($sformatf("rr%0d_latency", k), cyc, 4);
      exp_seq = ~exp_seq;
    end
    release_req(2'b11);

    // AW stalled 3 cycles, W immediate; then the mirror case.
    for (int s = 0; s < 2; s++) begin
      aw_delay = (s == 0) ? 3 : 0;
      w_delay  = (s == 0) ? 0 : 3;
      b_before = b_done;
      issue(0, 1, 4'h8, 32'h55 + s);
      @(negedge ACLK); @(negedge ACLK);
      chk($sformatf("st%0d_both_valid", s), {awvalid, wvalid}, 2'b11);
      @(negedge ACLK);
      chk($sformatf("st%0d_one_dropped", s), {awvalid, wvalid}, s == 0 ? 2'b10 : 2'b01);
      chk($sformatf("st%0d_no_bready", s), bready, 1'b0);
      wait_ack(cyc, a, rd, rs);
      chk($sformatf("st%0d_latency", s), cyc + 3, 7);
      chk($sformatf("st%0d_ack", s), a, 2'b01);
      chk($sformatf("st%0d_one_b", s), b_done - b_before, 1);
      release_req(2'b01);
    end
    aw_delay = 0; w_delay = 0;

    // Reset while AWVALID waits for AWREADY.
    aw_delay = 20;
    issue(0, 1, 4'h0, 32'h77);
    @(negedge ACLK); @(negedge ACLK);
    chk("rst_mid_pre", awvalid, 1'b1);
    ack_before = ack_total;
    #1 ARESETN = 1'b0;
    #1;
    chk("rst_mid_outputs", {awvalid, wvalid, arvalid, busy, ack}, 6'b0);
    req = 2'b00;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    aw_delay = 0;
    repeat (2) @(negedge ACLK);
    chk("rst_mid_no_ack", ack_total - ack_before, 0);
    chk("rst_mid_idle", busy, 1'b0);
    @(posedge ACLK); #1;
    req_we = 2'b00; req_addr = {4'h4, 4'h0};
    req = 2'b11;
    wait_ack(cyc, a, rd, rs);
    chk("rst_first_grant", a, 2'b01);
    release_req(2'b11);
    repeat (3) @(negedge ACLK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axil_rr_master_arbiter.md
Name: axil_rr_master_arbiter

Overview:
- Shares one AXI4-Lite master port between two simple register-access requesters, e.g. a switch-poll sequencer and a LED-pattern sequencer, both driving the led/switch peripheral's four 32-bit registers.
- Arbitration is round-robin. Each request becomes exactly one single-beat AXI4-Lite write or read.
- The response data and response code are returned to the winning requester with a one-cycle ack.

Parameters:
- C_M_AXI_ADDR_WIDTH, 4: AXI address width (byte address).
- C_M_AXI_DATA_WIDTH, 32: AXI data width. The only supported value is 32.

Ports:
- ACLK  in  1  system clock; all logic on the rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- req  in  2  per-requester request level; bit i = requester i.
- req_we  in  2  1 = write, 0 = read; sampled with req.
- req_addr  in  2*AW  requester i address at [i*AW +: AW].
- req_wdata  in  64  requester i write data at [i*32 +: 32].
- ack  out  2  one-cycle completion pulse to the granted requester.
- rsp_rdata  out  32  read data; valid while ack is high.
- rsp_resp  out  2  BRESP or RRESP of the completed transfer; valid while ack is high.
- busy  out  1  high in every state except IDLE.
- M_AXI_AWADDR  out  AW; M_AXI_AWPROT  out  3; M_AXI_AWVALID  out  1; M_AXI_AWREADY  in  1.
- M_AXI_WDATA  out  32; M_AXI_WSTRB  out  4; M_AXI_WVALID  out  1; M_AXI_WREADY  in  1.
- M_AXI_BRESP  in  2; M_AXI_BVALID  in  1; M_AXI_BREADY  out  1.
- M_AXI_ARADDR  out  AW; M_AXI_ARPROT  out  3; M_AXI_ARVALID  out  1; M_AXI_ARREADY  in  1.
- M_AXI_RDATA  in  32; M_AXI_RRESP  in  2; M_AXI_RVALID  in  1; M_AXI_RREADY  out  1.

Behaviour:
- Reset (ARESETN low, asynchronous): state = IDLE; last_grant = 1, so requester 0 wins first.
- Reset values: all VALID and READY outputs 0, ack = 0, rsp_rdata = 0, rsp_resp = 0, busy = 0, address and data registers 0.
- Reset mid-transfer: outputs go low immediately. No completion is reported and the transfer is not resumed after reset.
- Constant outputs: AWPROT = ARPROT = 3'b000; WSTRB = 4'hF.
- FSM states: IDLE, WR (AW/W phase), WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - If any req bit is high, grant by round-robin. With both high, grant the requester != last_grant; with one high, grant it.
  - Latch addr, wdata and we of the winner and update last_grant.
  - Go to WR if we = 1, else RD_ADDR. No grant if req = 0.
- WR:
  - AWVALID and WVALID both asserted on entry, i.e. the cycle after the grant.
  - Each VALID drops independently on the edge after its own VALID&READY handshake. AWREADY and WREADY may arrive in either order, or in the same cycle.
  - Go to WR_RESP once both handshakes have completed.
- WR_RESP: BREADY = 1. On BVALID, capture BRESP into rsp_resp and go to DONE.
- RD_ADDR: ARVALID = 1 until the ARREADY handshake, then go to RD_DATA.
- RD_DATA: RREADY = 1. On RVALID, capture RDATA and RRESP and go to DONE.
- DONE:
  - ack[grant] = 1 for exactly one cycle, with rsp_* valid; then go to IDLE.
  - rsp_rdata and rsp_resp hold their values until the next DONE.
  - For writes, rsp_rdata is unchanged.
- VALID stability: a VALID, once asserted, never drops before its READY. Address and data are stable while VALID is high.
- Requester rule: hold req and its fields stable until ack; drop req on the edge where ack is sampled high. A req still high in the IDLE cycle after ack is treated as a new request.
- Latency with a zero-wait slave:
  - write: grant edge to ack = 4 cycles (IDLE, WR, WR_RESP, DONE);
  - read: grant edge to ack = 4 cycles (IDLE, RD_ADDR, RD_DATA, DONE).
- Error responses: SLVERR and DECERR are passed through unmodified; no retry.
- Slave stalls: no timeout; the FSM waits indefinitely.

Test Plan:
- Req0 write addr 0x0, data 0x00000001, zero-wait slave:
  - AWADDR = 0x0, WDATA = 0x1 and WSTRB = 0xF, both VALIDs rise the cycle after grant;
  - BREADY rises in WR_RESP;
  - ack = 2'b01 four cycles after grant, rsp_resp = 2'b00.
- Write 1, 2, 3, 4 to 0x0/0x4/0x8/0xC via req0, then read all four via req1:
  - every read ack shows the matching rsp_rdata, rsp_resp = 0, ack = 2'b10.
- req = 2'b11 held continuously, each requester re-requesting right after its ack:
  - grants alternate 0, 1, 0, 1;
  - neither requester is granted twice in a row while the other waits.
- Write with AWREADY delayed 3 cycles and WREADY immediate, then again with the delays swapped:
  - WVALID drops after its own handshake while AWVALID stays high;
  - exactly one B phase per write; ack only after BVALID.
- Read with slave returning RRESP = 2'b10 and RDATA = 0xDEADBEEF:
  - ack carries rsp_resp = 2'b10 and rsp_rdata = 0xDEADBEEF;
  - FSM returns to IDLE; busy = 0.
- ARESETN pulled low while AWVALID is high and awaiting AWREADY:
  - all VALID outputs, busy and ack are 0 in the same cycle, no ack pulse;
  - after release, the first grant goes to requester 0 when both request.
